// File: rtl/tpu_feed_ctrl.sv
// Operand feed sequencer for the Mini-TPU 4x4 operand memory: stream load, skewed column reads, drain, done.
// Optional macro FEED_TRANSPOSE_EN stores the load stream transposed (line/elem swapped).
module tpu_feed_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  skip_load,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_write_enable,
  output logic [1:0]            mem_write_line,
  output logic [1:0]            mem_write_elem,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [3:0]            mem_read_enable,
  output logic [7:0]            mem_read_elem,
  output logic                  feed_valid,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  // Load stream handshake: a beat transfers on any cycle where in_valid and in_ready are both high;
  // in_ready is high for the whole LOAD state and never depends on in_valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  state_t     state, state_nxt;
  logic [3:0] bcnt, bcnt_nxt;
  logic [2:0] s, s_nxt;
  logic [3:0] dcnt, dcnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= 4'd0;
      s     <= 3'd0;
      dcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      s     <= s_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    s_nxt     = s;
    dcnt_nxt  = dcnt;
    if (abort) begin
      state_nxt = IDLE;
      bcnt_nxt  = 4'd0;
      s_nxt     = 3'd0;
      dcnt_nxt  = 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state_nxt = IDLE;
          if (start) begin
            if (skip_load) begin
              state_nxt = FEED;
              s_nxt     = 3'd0;
            end else begin
              state_nxt = LOAD;
              bcnt_nxt  = 4'd0;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (bcnt == 4'd15) begin
              state_nxt = FEED;
              bcnt_nxt  = 4'd0;
              s_nxt     = 3'd0;
            end else begin
              bcnt_nxt = bcnt + 4'd1;
            end
          end
        end
        FEED: begin
          if (s == 3'd6) begin
            s_nxt = 3'd0;
            if (DRAIN_CYCLES == 0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = DRAIN;
              dcnt_nxt  = 4'd0;
            end
          end else begin
            s_nxt = s + 3'd1;
          end
        end
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            state_nxt = DONE;
            dcnt_nxt  = 4'd0;
          end else begin
            dcnt_nxt = dcnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Diagonal skew: column i is live for steps i..i+3 and walks rows 0..3 in that window.
  always_comb begin
    mem_read_enable = 4'd0;
    mem_read_elem   = 8'd0;
    if (state == FEED) begin
      for (int i = 0; i < 4; i++) begin
        if ((s >= 3'(i)) && (s <= 3'(i + 3))) begin
          mem_read_enable[i]     = 1'b1;
          mem_read_elem[2*i +: 2] = 2'(s - 3'(i));
        end
      end
    end
  end

  assign in_ready         = (state == LOAD);
  assign mem_write_enable = in_valid & in_ready;
  assign mem_data_in      = in_data;

`ifdef FEED_TRANSPOSE_EN
  assign mem_write_line = in_ready ? bcnt[1:0] : 2'd0;
  assign mem_write_elem = in_ready ? bcnt[3:2] : 2'd0;
`else
  assign mem_write_line = in_ready ? bcnt[3:2] : 2'd0;
  assign mem_write_elem = in_ready ? bcnt[1:0] : 2'd0;
`endif

  assign feed_valid = (state == FEED);
  assign busy       = (state == LOAD) || (state == FEED) || (state == DRAIN);
  assign done       = (state == DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_tpu_feed_ctrl.sv
// Directed bench for tpu_feed_ctrl: reset, load, skewed feed, drain/done, back-to-back, stalls, abort.
module tb_tpu_feed_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       skip_load;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_write_enable;
  logic [1:0] mem_write_line;
  logic [1:0] mem_write_elem;
  logic [7:0] mem_data_in;
  logic [3:0] mem_read_enable;
  logic [7:0] mem_read_elem;
  logic       feed_valid;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Hand-derived feed pattern for steps s = 0..6.
  logic [3:0] exp_en   [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [7:0] exp_elem [7] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C, 8'hB0, 8'hC0};

  tpu_feed_ctrl #(.DATA_WIDTH(8), .DRAIN_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .skip_load        (skip_load),
    .abort            (abort),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .mem_write_enable (mem_write_enable),
    .mem_write_line   (mem_write_line),
    .mem_write_elem   (mem_write_elem),
    .mem_data_in      (mem_data_in),
    .mem_read_enable  (mem_read_enable),
    .mem_read_elem    (mem_read_elem),
    .feed_valid       (feed_valid),
    .busy             (busy),
    .done             (done),
    .state_dbg        (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; skip_load = 1'b0; abort = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    tests_run++;
    if ({in_ready, mem_write_enable, mem_read_enable, mem_read_elem, feed_valid, busy, done, state_dbg} !== 19'd0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got rdy=%b we=%b ren=%h relem=%h fv=%b busy=%b done=%b st=%0d, want all 0",
               in_ready, mem_write_enable, mem_read_enable, mem_read_elem, feed_valid, busy, done, state_dbg);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_feed;
    @(negedge clk); start = 1'b1; skip_load = 1'b1;
    @(negedge clk); start = 1'b0; skip_load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({mem_read_enable, mem_read_elem, feed_valid} !== {4'hF, 8'h1B, 1'b1}) begin
      fail_cnt++;
      $display("FAIL pre_reset_s3: got ren=%h relem=%h fv=%b, want F 1b 1", mem_read_enable, mem_read_elem, feed_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, mem_write_enable, mem_read_enable, mem_read_elem, feed_valid, busy, done, state_dbg} !== 19'd0) begin
      fail_cnt++;
      $display("FAIL async_reset_feed: got ren=%h relem=%h fv=%b busy=%b done=%b st=%0d, want all 0",
               mem_read_enable, mem_read_elem, feed_valid, busy, done, state_dbg);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if ({busy, feed_valid, state_dbg} !== {1'b0, 1'b0, 3'd0}) begin
      fail_cnt++;
      $display("FAIL post_reset_idle: got busy=%b fv=%b st=%0d, want 0 0 0", busy, feed_valid, state_dbg);
    end
  endtask

  task automatic test_load_and_feed;
    logic [1:0] el, ee;
    @(negedge clk); start = 1'b1; skip_load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'(k);
      #1;
`ifdef FEED_TRANSPOSE_EN
      el = 2'(k & 3); ee = 2'(k >> 2);
`else
      el = 2'(k >> 2); ee = 2'(k & 3);
`endif
      tests_run++;
      if ({in_ready, mem_write_enable, mem_write_line, mem_write_elem, mem_data_in, busy, feed_valid}
          !== {1'b1, 1'b1, el, ee, 8'(k), 1'b1, 1'b0}) begin
        fail_cnt++;
        $display("FAIL load_beat%0d: got rdy=%b we=%b line=%0d elem=%0d data=%h busy=%b fv=%b, want 1 1 %0d %0d %h 1 0",
                 k, in_ready, mem_write_enable, mem_write_line, mem_write_elem, mem_data_in, busy, feed_valid, el, ee, k);
      end
    end
    for (int st = 0; st < 7; st++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'hEE;
      #1;
      tests_run++;
      if ({feed_valid, busy, in_ready, mem_write_enable, mem_read_enable, mem_read_elem, done}
          !== {1'b1, 1'b1, 1'b0, 1'b0, exp_en[st], exp_elem[st], 1'b0}) begin
        fail_cnt++;
        $display("FAIL feed_s%0d: got fv=%b busy=%b rdy=%b we=%b ren=%h relem=%h done=%b, want 1 1 0 0 %h %h 0",
                 st, feed_valid, busy, in_ready, mem_write_enable, mem_read_enable, mem_read_elem, done,
                 exp_en[st], exp_elem[st]);
      end
    end
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({busy, done, feed_valid, mem_read_enable, mem_read_elem, mem_write_enable} !== {1'b1, 1'b0, 14'd0}) begin
        fail_cnt++;
        $display("FAIL drain_%0d: got busy=%b done=%b fv=%b ren=%h relem=%h we=%b, want busy=1 rest 0",
                 d, busy, done, feed_valid, mem_read_enable, mem_read_elem, mem_write_enable);
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if ({done, busy, feed_valid} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL done_pulse: got done=%b busy=%b fv=%b, want 1 0 0", done, busy, feed_valid);
    end
  endtask

  // Entered while the DUT sits in its DONE cycle.
  task automatic test_back_to_back;
    start = 1'b1; skip_load = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    for (int st = 0; st < 7; st++) begin
      @(negedge clk); start = 1'b0; skip_load = 1'b0;
      #1;
      tests_run++;
      if ({feed_valid, done, in_ready, mem_write_enable, mem_read_enable, mem_read_elem}
          !== {1'b1, 1'b0, 1'b0, 1'b0, exp_en[st], exp_elem[st]}) begin
        fail_cnt++;
        $display("FAIL b2b_feed_s%0d: got fv=%b done=%b rdy=%b we=%b ren=%h relem=%h, want 1 0 0 0 %h %h",
                 st, feed_valid, done, in_ready, mem_write_enable, mem_read_enable, mem_read_elem,
                 exp_en[st], exp_elem[st]);
      end
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (done !== 1'b1) begin
      fail_cnt++;
      $display("FAIL b2b_done: got done=%b, want 1", done);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({done, busy, state_dbg} !== {1'b0, 1'b0, 3'd0}) begin
      fail_cnt++;
      $display("FAIL done_to_idle: got done=%b busy=%b st=%0d, want 0 0 0", done, busy, state_dbg);
    end
  endtask

  task automatic test_load_stall;
    int b;
    logic [1:0] el, ee;
    b = 0;
    @(negedge clk); start = 1'b1; skip_load = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk); start = 1'b0; in_valid = (c != 5) && (c != 11); in_data = 8'(c);
      #1;
`ifdef FEED_TRANSPOSE_EN
      el = 2'(b & 3); ee = 2'(b >> 2);
`else
      el = 2'(b >> 2); ee = 2'(b & 3);
`endif
      tests_run++;
      if (in_valid) begin
        if ({in_ready, mem_write_enable, mem_write_line, mem_write_elem} !== {1'b1, 1'b1, el, ee}) begin
          fail_cnt++;
          $display("FAIL stall_beat%0d: got rdy=%b we=%b line=%0d elem=%0d, want 1 1 %0d %0d",
                   b, in_ready, mem_write_enable, mem_write_line, mem_write_elem, el, ee);
        end
        b++;
      end else if ({in_ready, mem_write_enable} !== 2'b10) begin
        fail_cnt++;
        $display("FAIL stall_cycle%0d: got rdy=%b we=%b, want 1 0", c, in_ready, mem_write_enable);
      end
    end
    @(negedge clk); in_valid = 1'b0; abort = 1'b1;
    #1;
    tests_run++;
    if ({feed_valid, in_ready, mem_read_enable} !== {1'b1, 1'b0, 4'h1}) begin
      fail_cnt++;
      $display("FAIL stall_feed_after_18: got fv=%b rdy=%b ren=%h, want 1 0 1", feed_valid, in_ready, mem_read_enable);
    end
    @(negedge clk); abort = 1'b0;
    #1;
    tests_run++;
    if ({busy, feed_valid, done, state_dbg} !== 6'd0) begin
      fail_cnt++;
      $display("FAIL abort_feed: got busy=%b fv=%b done=%b st=%0d, want 0 0 0 0", busy, feed_valid, done, state_dbg);
    end
  endtask

  task automatic test_abort_load;
    @(negedge clk); start = 1'b1; skip_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'(8'h40 + k); abort = (k == 7);
      #1;
      if (k == 6) begin
        tests_run++;
`ifdef FEED_TRANSPOSE_EN
        if ({mem_write_line, mem_write_elem} !== {2'd2, 2'd1}) begin
          fail_cnt++;
          $display("FAIL transpose_beat6: got line=%0d elem=%0d, want 2 1", mem_write_line, mem_write_elem);
        end
`else
        if ({mem_write_line, mem_write_elem} !== {2'd1, 2'd2}) begin
          fail_cnt++;
          $display("FAIL beat6_addr: got line=%0d elem=%0d, want 1 2", mem_write_line, mem_write_elem);
        end
`endif
      end
    end
    tests_run++;
`ifdef FEED_TRANSPOSE_EN
    if ({mem_write_enable, mem_write_line, mem_write_elem, mem_data_in} !== {1'b1, 2'd3, 2'd1, 8'h47}) begin
`else
    if ({mem_write_enable, mem_write_line, mem_write_elem, mem_data_in} !== {1'b1, 2'd1, 2'd3, 8'h47}) begin
`endif
      fail_cnt++;
      $display("FAIL abort_beat_written: got we=%b line=%0d elem=%0d data=%h, want beat 7 written",
               mem_write_enable, mem_write_line, mem_write_elem, mem_data_in);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); abort = 1'b0; in_valid = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, in_ready, state_dbg} !== 6'd0) begin
        fail_cnt++;
        $display("FAIL abort_load_idle%0d: got busy=%b done=%b rdy=%b st=%0d, want 0 0 0 0",
                 c, busy, done, in_ready, state_dbg);
      end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    #1;
    tests_run++;
    if ({mem_write_enable, mem_write_line, mem_write_elem} !== {1'b1, 2'd0, 2'd0}) begin
      fail_cnt++;
      $display("FAIL restart_bcnt_cleared: got we=%b line=%0d elem=%0d, want 1 0 0",
               mem_write_enable, mem_write_line, mem_write_elem);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_feed();
    test_load_and_feed();
    test_back_to_back();
    test_load_stall();
    test_abort_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/tpu_feed_ctrl.md
Name: tpu_feed_ctrl

Overview:
Sequencer for the 4x4 operand memory of the Mini-TPU. It loads 16 bytes from a valid/ready stream into the memory, then drives the memory's per-column read port. The reads follow a diagonal (systolic) skew, so column i starts i cycles after column 0 and the 4-wide array receives correctly staggered operands. After feeding, it holds for a drain window and pulses done.

Parameters:
DATA_WIDTH, 8, operand width; matches the memory cell width
DRAIN_CYCLES, 4, idle cycles after the feed so the array pipeline can flush (0 allowed, max 15)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin an operation; sampled only in IDLE or DONE
skip_load  input  1  sampled with start; 1 = go straight to FEED and reuse the stored operands
abort  input  1  synchronous abort; any state -> IDLE next cycle, no done pulse
in_valid  input  1  load stream beat valid
in_data  input  DATA_WIDTH  load stream data
in_ready  output  1  high in LOAD only
mem_write_enable  output  1  = in_valid & in_ready (combinational)
mem_write_line  output  2  memory column for the current beat
mem_write_elem  output  2  memory row for the current beat
mem_data_in  output  DATA_WIDTH  = in_data (combinational pass-through)
mem_read_enable  output  4  per-column read enable
mem_read_elem  output  8  4x2-bit row select; column i uses bits [2i+1:2i]
feed_valid  output  1  high on every FEED cycle; array compute enable
busy  output  1  high in LOAD, FEED, DRAIN
done  output  1  one-cycle pulse in DONE

Behaviour:
- States: IDLE, LOAD, FEED, DRAIN, DONE. Registers: state, beat counter bcnt[3:0], step counter s[2:0], drain counter dcnt[3:0].
- Reset (async, rst_n low): state = IDLE, all counters 0. All outputs 0: in_ready, mem_write_enable, mem_read_enable, mem_read_elem, feed_valid, busy, done.
- IDLE/DONE:
  - start=1 and skip_load=0 -> LOAD, bcnt=0.
  - start=1 and skip_load=1 -> FEED, s=0.
  - DONE with no start -> IDLE.
- start while busy is ignored.
- LOAD:
  - in_ready=1.
  - Each accepted beat writes to line=bcnt[3:2], elem=bcnt[1:0], then bcnt increments.
  - Cycles with in_valid=0 stall the load and write nothing.
  - Acceptance of beat 15 -> FEED next cycle, s=0.
- FEED:
  - Runs exactly 7 cycles, s = 0..6, with feed_valid=1.
  - Column i: mem_read_enable[i] = (s >= i) && (s <= i+3).
  - When enabled, column i reads row (s-i) mod 4; when disabled, its elem field = 0.
  - Write outputs are 0 during FEED.
  - At s=6: if DRAIN_CYCLES = 0, next state is DONE; otherwise DRAIN with dcnt=0.
- DRAIN:
  - All read and write outputs are 0.
  - Lasts exactly DRAIN_CYCLES cycles, then DONE.
- DONE: done=1 for exactly 1 cycle. start in that same cycle is honoured (back-to-back operations, no IDLE bubble).
- Output paths:
  - All read-side outputs, busy, done and feed_valid decode from registers only; there is no combinational path from inputs to them.
  - Only mem_write_enable and mem_data_in have a combinational path from the stream inputs.
- abort:
  - Has priority over every other transition.
  - Clears counters; the beat presented in the abort cycle is still written if in_valid & in_ready.
  - Memory contents are not cleared.
- Counters wrap-free: bcnt, s and dcnt never exceed their terminal values.

Optional Feature:
FEED_TRANSPOSE_EN
- Defined: the load stores transposed, with mem_write_line = bcnt[1:0] and mem_write_elem = bcnt[3:2]. Feed timing is unchanged. The array therefore receives A^T from the same row-major stream.
- Undefined: row-major store as specified above.

Test Plan:
1. Reset mid-FEED at s=3 -> all outputs 0 immediately, before the next clk edge; state IDLE.
2. start=1, skip_load=0; 16 beats of data 0x00..0x0F with in_valid held high -> beat k writes line k>>2, elem k&3. FEED begins the cycle after beat 15.
3. Load with in_valid low on beats 5 and 10 -> exactly 16 writes, no duplicates; total LOAD length 18 cycles.
4. FEED check: s=0 -> read_enable=0001, read_elem=0x00; s=3 -> 1111, 0x1B; s=6 -> 1000, read_elem=0xC0. feed_valid high for 7 cycles.
5. DRAIN_CYCLES=4 -> done pulses 4 cycles after the last FEED cycle; start with skip_load=1 in the done cycle -> FEED next cycle, no writes.
6. abort in LOAD at beat 7 -> IDLE next cycle, no done, busy=0. Build with FEED_TRANSPOSE_EN: beat 6 writes line 2, elem 1.
